maze_level_engine: RTL and testbench

Parametrised maze-level engine for the VGA maze runner. It replaces the hard-coded per-level modules with one block configured by parameters: the corridor rectangle list, the start zone, the finish zone, player size and step size. It owns player position, collision, death/respawn and win state, and it produces registered 4-bit RGB for the current VGA `col`/`row`. It sits between the VGA timing generator and the level-select mux; one instance per level.

---
 rtl/maze_level_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_maze_level_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_level_engine.sv
// One parametrised maze level: tick generator, player movement with rectangle collision,
// death/respawn and win handling, and registered 4-bit RGB for the current VGA pixel.
//
// state  | meaning
// S_PLAY | switches move the player one step per tick
// S_DEAD | collision happened; wait DEAD_TICKS ticks, then respawn at start
// S_WIN  | player box inside finish zone; frozen until reset
module maze_level_engine #(
    parameter int                      NUM_RECTS   = 4,
    parameter logic [NUM_RECTS*10-1:0] RECT_X      = {10'd80,  10'd280, 10'd0,   10'd0},
    parameter logic [NUM_RECTS*10-1:0] RECT_Y      = {10'd20,  10'd220, 10'd220, 10'd90},
    parameter logic [NUM_RECTS*10-1:0] RECT_W      = {10'd160, 10'd340, 10'd320, 10'd50},
    parameter logic [NUM_RECTS*10-1:0] RECT_H      = {10'd100, 10'd35,  10'd35,  10'd300},
    parameter int                      START_X     = 13,
    parameter int                      START_Y     = 230,
    parameter int                      START_W     = 50,
    parameter int                      START_H     = 300,
    parameter int                      START_RX    = 0,
    parameter int                      START_RY    = 90,
    parameter int                      FIN_X       = 570,
    parameter int                      FIN_Y       = 220,
    parameter int                      FIN_W       = 50,
    parameter int                      FIN_H       = 35,
    parameter int                      PLAYER_SIZE = 25,
    parameter int                      STEP        = 5,
    parameter int                      TICK_DIV    = 416667,
    parameter int                      DEAD_TICKS  = 30
) (
    input  logic       pixel_clk,
    input  logic       resetSwitch,
    input  logic [9:0] col,
    input  logic [8:0] row,
    input  logic [3:0] switches,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       level_done,
    output logic [7:0] death_count
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEAD_TICKS + 1);

    localparam logic [9:0]        X0     = 10'(START_X);
    localparam logic [9:0]        Y0     = 10'(START_Y);
    localparam logic [9:0]        PS10   = 10'(PLAYER_SIZE);
    localparam logic signed [11:0] PS_S   = 12'(PLAYER_SIZE);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_DEAD = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [TW-1:0]   r_tick_cnt;
    logic [DW-1:0]   r_dead_cnt;
    logic [7:0]      r_death_cnt;
    logic            r_level_done;
    logic [11:0]     r_rgb;

    logic            w_tick;
    logic            w_dead_last;
    logic            w_move;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic            w_fit;
    logic            w_legal;
    logic            w_finish;
    logic [10:0]     w_c;
    logic [10:0]     w_r;
    logic            w_in_player;
    logic            w_in_fin;
    logic            w_in_start;
    logic            w_in_rect;
    logic [11:0]     w_rgb;

    // Inclusive containment of the candidate player box inside a zone.
    function automatic logic box_fits(input logic signed [11:0] px,
                                      input logic signed [11:0] py,
                                      input logic [9:0]         zx,
                                      input logic [9:0]         zy,
                                      input logic [9:0]         zw,
                                      input logic [9:0]         zh);
        logic signed [11:0] lx, ly, hx, hy;
        lx = signed'({2'b00, zx});
        ly = signed'({2'b00, zy});
        hx = lx + signed'({2'b00, zw});
        hy = ly + signed'({2'b00, zh});
        return (px >= lx) && (px + PS_S <= hx) && (py >= ly) && (py + PS_S <= hy);
    endfunction

    function automatic logic in_span(input logic [10:0] p,
                                     input logic [9:0]  lo,
                                     input logic [9:0]  len);
        return (p >= {1'b0, lo}) && (p < ({1'b0, lo} + {1'b0, len}));
    endfunction

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_dead_last = (r_dead_cnt == DW'(DEAD_TICKS - 1));

    always_comb begin
        w_nx   = signed'({2'b00, r_x});
        w_ny   = signed'({2'b00, r_y});
        w_move = |switches;
        if (switches[3]) begin
            w_nx = signed'({2'b00, r_x}) - STEP_S;
        end else if (switches[2]) begin
            w_ny = signed'({2'b00, r_y}) - STEP_S;
        end else if (switches[1]) begin
            w_ny = signed'({2'b00, r_y}) + STEP_S;
        end else if (switches[0]) begin
            w_nx = signed'({2'b00, r_x}) + STEP_S;
        end

        w_fit = 1'b0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            if (box_fits(w_nx, w_ny, RECT_X[10*i +: 10], RECT_Y[10*i +: 10],
                         RECT_W[10*i +: 10], RECT_H[10*i +: 10])) begin
                w_fit = 1'b1;
            end
        end
        w_legal  = !w_nx[11] && !w_ny[11] && w_fit;
        w_finish = box_fits(w_nx, w_ny, 10'(FIN_X), 10'(FIN_Y), 10'(FIN_W), 10'(FIN_H));
    end

    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_state      <= S_PLAY;
            r_x          <= X0;
            r_y          <= Y0;
            r_tick_cnt   <= '0;
            r_dead_cnt   <= '0;
            r_death_cnt  <= '0;
            r_level_done <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_level_done <= (r_state == S_WIN);
            if (w_tick) begin
                case (r_state)
                    S_PLAY: begin
                        if (w_move) begin
                            if (w_legal) begin
                                r_x <= w_nx[9:0];
                                r_y <= w_ny[9:0];
                                if (w_finish) begin
                                    r_state <= S_WIN;
                                end
                            end else begin
                                if (r_death_cnt != 8'hFF) begin
                                    r_death_cnt <= r_death_cnt + 8'd1;
                                end
                                r_dead_cnt <= '0;
                                r_state    <= S_DEAD;
                            end
                        end
                    end
                    S_DEAD: begin
                        if (w_dead_last) begin
                            r_x     <= X0;
                            r_y     <= Y0;
                            r_state <= S_PLAY;
                        end else begin
                            r_dead_cnt <= r_dead_cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Pixel sums are 11 bits wide so zones near the right edge never wrap.
    always_comb begin
        w_c         = {1'b0, col};
        w_r         = {2'b00, row};
        w_in_player = in_span(w_c, r_x, PS10) && in_span(w_r, r_y, PS10);
        w_in_fin    = in_span(w_c, 10'(FIN_X), 10'(FIN_W)) && in_span(w_r, 10'(FIN_Y), 10'(FIN_H));
        w_in_start  = in_span(w_c, 10'(START_RX), 10'(START_W))
                   && in_span(w_r, 10'(START_RY), 10'(START_H));
        w_in_rect   = 1'b0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            if (in_span(w_c, RECT_X[10*i +: 10], RECT_W[10*i +: 10])
                && in_span(w_r, RECT_Y[10*i +: 10], RECT_H[10*i +: 10])) begin
                w_in_rect = 1'b1;
            end
        end

        if (w_in_player) begin
            case (r_state)
                S_DEAD:  w_rgb = 12'hF00;
                S_WIN:   w_rgb = 12'hFF0;
                default: w_rgb = 12'hF0F;
            endcase
        end else if (w_in_fin) begin
            w_rgb = 12'hF00;
        end else if (w_in_start) begin
            w_rgb = 12'h0F0;
        end else if (w_in_rect) begin
            w_rgb = 12'hFFF;
        end else begin
            w_rgb = 12'h000;
        end
    end

    always_ff @(posedge pixel_clk or negedge resetSwitch) begin
        if (!resetSwitch) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];
    assign level_done  = r_level_done;
    assign death_count = r_death_cnt;

endmodule

// File: tb/tb_maze_level_engine.sv
// Randomized bench for maze_level_engine against a tick-level behavioural model of the level.
module tb_maze_level_engine;

    localparam int TD   = 4;
    localparam int DT   = 3;
    localparam int PS   = 25;
    localparam int STEP = 5;
    localparam int SX = 13,  SY = 230;
    localparam int ZX = 0,   ZY = 90,  ZW = 50, ZH = 300;
    localparam int FX = 570, FY = 220, FW = 50, FH = 35;
    localparam int NR = 4;

    int rx[NR] = '{0,   0,   280, 80};
    int ry[NR] = '{90,  220, 220, 20};
    int rw[NR] = '{50,  320, 340, 160};
    int rh[NR] = '{300, 35,  35,  100};

    logic       pixel_clk;
    logic       resetSwitch;
    logic [9:0] col;
    logic [8:0] row;
    logic [3:0] switches;
    logic [3:0] red, green, blue;
    logic       level_done;
    logic [7:0] death_count;

    maze_level_engine #(
        .NUM_RECTS(4),
        .RECT_X({10'd80,  10'd280, 10'd0,   10'd0}),
        .RECT_Y({10'd20,  10'd220, 10'd220, 10'd90}),
        .RECT_W({10'd160, 10'd340, 10'd320, 10'd50}),
        .RECT_H({10'd100, 10'd35,  10'd35,  10'd300}),
        .START_X(SX), .START_Y(SY),
        .START_W(ZW), .START_H(ZH), .START_RX(ZX), .START_RY(ZY),
        .FIN_X(FX), .FIN_Y(FY), .FIN_W(FW), .FIN_H(FH),
        .PLAYER_SIZE(PS), .STEP(STEP), .TICK_DIV(TD), .DEAD_TICKS(DT)
    ) dut (
        .pixel_clk(pixel_clk),
        .resetSwitch(resetSwitch),
        .col(col),
        .row(row),
        .switches(switches),
        .red(red),
        .green(green),
        .blue(blue),
        .level_done(level_done),
        .death_count(death_count)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 play, 1 dead, 2 win
    int m_x, m_y, m_st, m_cnt, m_dead, m_deaths;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit span(input int p, input int lo, input int len);
        return (p >= lo) && (p < lo + len);
    endfunction

    function automatic bit inside_zone(input int x, input int y, input int zx, input int zy,
                                       input int zw, input int zh);
        return (x >= zx) && (x + PS <= zx + zw) && (y >= zy) && (y + PS <= zy + zh);
    endfunction

    function automatic logic [11:0] colour(input int c, input int r);
        if (span(c, m_x, PS) && span(r, m_y, PS))
            return (m_st == 0) ? 12'hF0F : (m_st == 1) ? 12'hF00 : 12'hFF0;
        if (span(c, FX, FW) && span(r, FY, FH)) return 12'hF00;
        if (span(c, ZX, ZW) && span(r, ZY, ZH)) return 12'h0F0;
        for (int i = 0; i < NR; i++)
            if (span(c, rx[i], rw[i]) && span(r, ry[i], rh[i])) return 12'hFFF;
        return 12'h000;
    endfunction

    function automatic bit legal(input int x, input int y);
        if (x < 0 || y < 0) return 1'b0;
        for (int i = 0; i < NR; i++)
            if (inside_zone(x, y, rx[i], ry[i], rw[i], rh[i])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_init();
        m_x = SX; m_y = SY; m_st = 0; m_cnt = 0; m_dead = 0; m_deaths = 0;
    endtask

    task automatic model_tick(input logic [3:0] sw);
        int nx, ny;
        nx = m_x; ny = m_y;
        if (m_st == 0 && sw != 4'b0) begin
            if (sw[3])      nx = m_x - STEP;
            else if (sw[2]) ny = m_y - STEP;
            else if (sw[1]) ny = m_y + STEP;
            else            nx = m_x + STEP;
            if (legal(nx, ny)) begin
                m_x = nx; m_y = ny;
                if (inside_zone(nx, ny, FX, FY, FW, FH)) m_st = 2;
            end else begin
                if (m_deaths < 255) m_deaths++;
                m_dead = 0;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            m_dead++;
            if (m_dead == DT) begin
                m_x = SX; m_y = SY; m_st = 0;
            end
        end
    endtask

    // Called at a falling edge: drive, advance one rising edge, check at the next falling edge.
    task automatic cyc(input logic [3:0] sw, input int c, input int r);
        logic [11:0] exp_rgb;
        int          exp_ld;
        switches = sw;
        col      = c[9:0];
        row      = r[8:0];
        exp_rgb  = colour(c, r);
        exp_ld   = (m_st == 2) ? 1 : 0;
        if (m_cnt == TD - 1) begin
            m_cnt = 0;
            model_tick(sw);
        end else begin
            m_cnt++;
        end
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("rgb", int'({red, green, blue}), int'(exp_rgb));
        chk("level_done", int'(level_done), exp_ld);
        chk("death_count", int'(death_count), m_deaths);
    endtask

    task automatic rnd_px(output int c, output int r);
        if ($urandom_range(0, 1) == 1) begin
            c = m_x + int'($urandom_range(0, 31)) - 3;
            r = m_y + int'($urandom_range(0, 31)) - 3;
        end else begin
            c = int'($urandom_range(0, 799));
            r = int'($urandom_range(0, 511));
        end
        if (c < 0) c = 0;
        if (r < 0) r = 0;
        if (r > 511) r = 511;
    endtask

    task automatic run(input int n, input logic [3:0] sw, input bit rnd_sw);
        int c, r;
        for (int i = 0; i < n; i++) begin
            rnd_px(c, r);
            cyc(rnd_sw ? 4'($urandom_range(0, 15)) : sw, c, r);
        end
    endtask

    task automatic run_until_dead(input logic [3:0] sw, input string tag);
        int c, r;
        for (int i = 0; i < 400 && m_st != 1; i++) begin
            rnd_px(c, r);
            cyc(sw, c, r);
        end
        chk({tag, "_reached_dead"}, int'(m_st == 1), 1);
    endtask

    // Asynchronous assert a little after a falling edge; release on a later falling edge.
    task automatic do_reset();
        #2 resetSwitch = 1'b0;
        #1;
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_level_done", int'(level_done), 0);
        chk("rst_death_count", int'(death_count), 0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        resetSwitch = 1'b1;
        model_init();
    endtask

    initial begin
        int c, r;
        resetSwitch = 1'b1;
        col = '0; row = '0; switches = '0;
        model_init();
        @(negedge pixel_clk);
        do_reset();

        run(100, 4'b0000, 1'b0);
        cyc(4'b0000, 20, 240);
        chk("idle_player_rgb", int'({red, green, blue}), 12'hF0F);
        cyc(4'b0000, 100, 100);
        chk("idle_corridor_rgb", int'({red, green, blue}), 12'hFFF);

        for (int i = 0; i < 1000 && m_st != 2; i++) begin
            rnd_px(c, r);
            cyc(4'b0001, c, r);
        end
        cyc(4'b0000, 0, 0);
        chk("win_level_done", int'(level_done), 1);
        chk("right_run_deaths", int'(death_count), 0);
        run(40, 4'b0000, 1'b1);
        cyc(4'($urandom_range(0, 15)), 575, 232);
        chk("win_player_yellow", int'({red, green, blue}), 12'hFF0);
        do_reset();

        run_until_dead(4'b1000, "left");
        cyc(4'b1000, 5, 240);
        chk("left_death_count", int'(death_count), 1);
        chk("left_dead_red", int'({red, green, blue}), 12'hF00);
        run(40, 4'b1001, 1'b0);
        do_reset();

        run_until_dead(4'b0100, "up");
        run(20, 4'b0000, 1'b0);
        do_reset();

        run(3000, 4'b0000, 1'b1);
        do_reset();

        run(7800, 4'b1000, 1'b0);
        chk("death_saturate", int'(death_count), 255);
        run_until_dead(4'b1000, "sat");
        cyc(4'b1000, 0, 0);
        do_reset();
        run(8, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
